// File: rtl/riscv_mem_access.sv
// MEM-stage data-memory responder: word-organised RAM with configurable wait
// states, pipeline stall while an access is in flight, and sign/zero-extended
// load results tagged with the destination register.
module riscv_mem_access #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_re_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  input  logic [2:0]            data_size_i,
  input  logic [4:0]            rd_idx_i,
  input  logic                  rd_we_i,
  output logic                  stall_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_valid_o,
  output logic [4:0]            rd_idx_o,
  output logic                  rd_we_o,
  output logic                  err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         count, count_nxt;
  logic               req, bad, accept, done;

  logic [IDX_W-1:0]   lat_idx;
  logic [1:0]         lat_off;
  logic [2:0]         lat_size;
  logic [31:0]        lat_wdata;
  logic [4:0]         lat_rd_idx;
  logic               lat_rd_we;
  logic               lat_load;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        rd_word;
  logic [31:0]        load_data;
  logic [3:0]         be;
  logic [31:0]        wd;

  // Upper address bits above the RAM index are intentionally ignored (aliasing).
  logic               unused_addr_bits;
  assign unused_addr_bits = ^data_addr_i[ADDR_WIDTH-1:IDX_W+2];

  // Request decode and rejection of malformed/misaligned accesses
  always_comb begin
    req = data_re_i | data_we_i;
    bad = 1'b0;
    if (data_re_i && data_we_i) bad = 1'b1;
    if (data_size_i == 3'b011 || data_size_i == 3'b110 || data_size_i == 3'b111) bad = 1'b1;
    if (data_we_i && data_size_i[2]) bad = 1'b1;
    if (data_size_i[1:0] == 2'b01 && data_addr_i[0]) bad = 1'b1;
    if (data_size_i == 3'b010 && data_addr_i[1:0] != 2'b00) bad = 1'b1;
  end

  // State and wait counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state, counter and stall decode
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    done      = 1'b0;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (req && !bad) begin
          accept    = 1'b1;
          stall_o   = 1'b1;
          state_nxt = BUSY;
          count_nxt = 4'(WAIT_CYCLES);
        end
      end
      BUSY: begin
        if (count != 4'd0) begin
          stall_o   = 1'b1;
          count_nxt = count - 4'd1;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the accepted request for the duration of the access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_idx    <= '0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_wdata  <= '0;
      lat_rd_idx <= '0;
      lat_rd_we  <= 1'b0;
      lat_load   <= 1'b0;
    end else if (accept) begin
      lat_idx    <= data_addr_i[IDX_W+1:2];
      lat_off    <= data_addr_i[1:0];
      lat_size   <= data_size_i;
      lat_wdata  <= data_wdata_i;
      lat_rd_idx <= rd_idx_i;
      lat_rd_we  <= rd_we_i;
      lat_load   <= data_re_i;
    end
  end

  // Load lane selection and extension
  always_comb begin
    rd_word   = mem[lat_idx];
    load_data = rd_word;
    case (lat_size)
      3'b000: load_data = {{24{rd_word[8*lat_off+7]}}, rd_word[8*lat_off +: 8]};
      3'b100: load_data = {24'h0, rd_word[8*lat_off +: 8]};
      3'b001: load_data = lat_off[1] ? {{16{rd_word[31]}}, rd_word[31:16]}
                                     : {{16{rd_word[15]}}, rd_word[15:0]};
      3'b101: load_data = lat_off[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Store byte-enable and lane-replicated write data
  always_comb begin
    be = 4'b1111;
    wd = lat_wdata;
    case (lat_size[1:0])
      2'b00: begin
        be = 4'b0001 << lat_off;
        wd = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        be = lat_off[1] ? 4'b1100 : 4'b0011;
        wd = {2{lat_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = lat_wdata;
      end
    endcase
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (done && !lat_load) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[lat_idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // Registered result/pulse outputs; rd_we_o is only high alongside data_valid_o
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_rdata_o <= '0;
      data_valid_o <= 1'b0;
      rd_idx_o     <= '0;
      rd_we_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o        <= (state == IDLE) && req && bad;
      data_valid_o <= done && lat_load;
      rd_we_o      <= done && lat_load && lat_rd_we;
      if (done && lat_load) begin
        data_rdata_o <= load_data;
        rd_idx_o     <= lat_rd_idx;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_access.sv
// Directed bench for riscv_mem_access: one instance with two wait states, one
// with zero wait states, both 1024 words deep.
module tb_riscv_mem_access;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_re, a_we, a_rwe, b_re, b_we, b_rwe;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [2:0]  a_size, b_size;
  logic [4:0]  a_rd, b_rd;

  logic        a_stall, a_valid, a_rd_we, a_err;
  logic [31:0] a_rdata;
  logic [4:0]  a_rd_idx;
  logic        b_stall, b_valid, b_rd_we, b_err;
  logic [31:0] b_rdata;
  logic [4:0]  b_rd_idx;

  logic        sel = 1'b0;
  logic        m_stall, m_valid, m_rd_we, m_err;
  logic [31:0] m_rdata;
  logic [4:0]  m_rd_idx;
  assign m_stall  = sel ? b_stall  : a_stall;
  assign m_valid  = sel ? b_valid  : a_valid;
  assign m_rd_we  = sel ? b_rd_we  : a_rd_we;
  assign m_err    = sel ? b_err    : a_err;
  assign m_rdata  = sel ? b_rdata  : a_rdata;
  assign m_rd_idx = sel ? b_rd_idx : a_rd_idx;

  riscv_mem_access #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .data_re_i(a_re), .data_we_i(a_we), .data_addr_i(a_addr), .data_wdata_i(a_wdata),
    .data_size_i(a_size), .rd_idx_i(a_rd), .rd_we_i(a_rwe),
    .stall_o(a_stall), .data_rdata_o(a_rdata), .data_valid_o(a_valid),
    .rd_idx_o(a_rd_idx), .rd_we_o(a_rd_we), .err_o(a_err)
  );

  riscv_mem_access #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .data_re_i(b_re), .data_we_i(b_we), .data_addr_i(b_addr), .data_wdata_i(b_wdata),
    .data_size_i(b_size), .rd_idx_i(b_rd), .rd_we_i(b_rwe),
    .stall_o(b_stall), .data_rdata_o(b_rdata), .data_valid_o(b_valid),
    .rd_idx_o(b_rd_idx), .rd_we_o(b_rd_we), .err_o(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit which, input logic re, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size, input logic [4:0] rd,
                       input logic rwe);
    if (which) begin
      b_re = re; b_we = we; b_addr = addr; b_wdata = wdata; b_size = size; b_rd = rd; b_rwe = rwe;
    end else begin
      a_re = re; a_we = we; a_addr = addr; a_wdata = wdata; a_size = size; a_rd = rd; a_rwe = rwe;
    end
  endtask

  // kind: 0 = store, 1 = load, 2 = rejected request
  task automatic access(input bit which, input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size, input logic [4:0] rd,
                        input logic rwe, input int exp_stall, input int kind,
                        input logic [31:0] exp_data, input logic [4:0] exp_rd, input string tag);
    int nstall;
    sel = which;
    @(posedge clk); #1;
    drive(which, re, we, addr, wdata, size, rd, rwe);
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_stall) nstall++;
      else break;
    end
    @(posedge clk); #1;
    drive(which, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check({tag, " stall_cycles"}, 32'(nstall), 32'(exp_stall));
    check({tag, " valid"}, 32'(m_valid), 32'(kind == 1));
    check({tag, " err"}, 32'(m_err), 32'(kind == 2));
    check({tag, " rdata"}, m_rdata, exp_data);
    check({tag, " rd_idx"}, 32'(m_rd_idx), 32'(exp_rd));
    check({tag, " rd_we"}, 32'(m_rd_we), 32'((kind == 1) && rwe));
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " valid_drop"}, 32'(m_valid), 32'h0);
    check({tag, " err_drop"}, 32'(m_err), 32'h0);
    check({tag, " rd_we_drop"}, 32'(m_rd_we), 32'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);

    // Power-on reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst rdata", a_rdata, 32'h0);
    check("rst valid", 32'(a_valid), 32'h0);
    check("rst rd_idx", 32'(a_rd_idx), 32'h0);
    check("rst rd_we", 32'(a_rd_we), 32'h0);
    check("rst err", 32'(a_err), 32'h0);
    check("rst stall", 32'(a_stall), 32'h0);
    check("rst0 valid", 32'(b_valid), 32'h0);
    rst = 1'b1;

    // Known value at 0x10, then a load to make the outputs non-zero
    access(0, 0, 1, 32'h10, 32'h11111111, 3'b010, 5'd0, 1'b0, 3, 0, 32'h0, 5'd0, "sw10");
    access(0, 1, 0, 32'h10, 32'h0, 3'b010, 5'd7, 1'b1, 3, 1, 32'h11111111, 5'd7, "lw10");

    // Abort an in-flight store by reset
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 5'd0, 1'b0);
    @(negedge clk);
    check("abort accept stall", 32'(a_stall), 32'h1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    #1;
    check("abort rdata", a_rdata, 32'h0);
    check("abort valid", 32'(a_valid), 32'h0);
    check("abort rd_idx", 32'(a_rd_idx), 32'h0);
    check("abort rd_we", 32'(a_rd_we), 32'h0);
    check("abort err", 32'(a_err), 32'h0);
    check("abort stall", 32'(a_stall), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    access(0, 1, 0, 32'h10, 32'h0, 3'b010, 5'd9, 1'b1, 3, 1, 32'h11111111, 5'd9, "lw10_after_abort");

    // Word store/load and extension cases on 0x80402010
    access(0, 0, 1, 32'h20, 32'h80402010, 3'b010, 5'd3, 1'b1, 3, 0, 32'h11111111, 5'd9, "sw20");
    access(0, 1, 0, 32'h20, 32'h0, 3'b010, 5'd5, 1'b1, 3, 1, 32'h80402010, 5'd5, "lw20");
    access(0, 1, 0, 32'h23, 32'h0, 3'b000, 5'd6, 1'b1, 3, 1, 32'hFFFFFF80, 5'd6, "lb23");
    access(0, 1, 0, 32'h23, 32'h0, 3'b100, 5'd7, 1'b1, 3, 1, 32'h00000080, 5'd7, "lbu23");
    access(0, 1, 0, 32'h22, 32'h0, 3'b001, 5'd8, 1'b1, 3, 1, 32'hFFFF8040, 5'd8, "lh22");
    access(0, 1, 0, 32'h20, 32'h0, 3'b101, 5'd10, 1'b0, 3, 1, 32'h00002010, 5'd10, "lhu20");
    access(0, 1, 0, 32'h20, 32'h0, 3'b000, 5'd11, 1'b1, 3, 1, 32'h00000010, 5'd11, "lb20");

    // Rejected requests: no stall, outputs held, RAM untouched
    access(0, 1, 0, 32'h21, 32'h0, 3'b001, 5'd12, 1'b1, 0, 2, 32'h00000010, 5'd11, "err_lh21");
    access(0, 0, 1, 32'h22, 32'hFFFFFFFF, 3'b010, 5'd12, 1'b1, 0, 2, 32'h00000010, 5'd11, "err_sw22");
    access(0, 1, 1, 32'h20, 32'hFFFFFFFF, 3'b010, 5'd12, 1'b1, 0, 2, 32'h00000010, 5'd11, "err_rewe");
    access(0, 1, 0, 32'h20, 32'h0, 3'b011, 5'd12, 1'b1, 0, 2, 32'h00000010, 5'd11, "err_size011");
    access(0, 0, 1, 32'h20, 32'hFFFFFFFF, 3'b100, 5'd12, 1'b1, 0, 2, 32'h00000010, 5'd11, "err_store_bu");
    access(0, 1, 0, 32'h20, 32'h0, 3'b010, 5'd13, 1'b1, 3, 1, 32'h80402010, 5'd13, "lw20_unchanged");

    // Partial stores over a zeroed word
    access(0, 0, 1, 32'h20, 32'h0, 3'b010, 5'd0, 1'b0, 3, 0, 32'h80402010, 5'd13, "sw20_zero");
    access(0, 0, 1, 32'h21, 32'hFFFFFFAA, 3'b000, 5'd0, 1'b0, 3, 0, 32'h80402010, 5'd13, "sb21");
    access(0, 0, 1, 32'h22, 32'hABCD1234, 3'b001, 5'd0, 1'b0, 3, 0, 32'h80402010, 5'd13, "sh22");
    access(0, 1, 0, 32'h20, 32'h0, 3'b010, 5'd14, 1'b1, 3, 1, 32'h1234AA00, 5'd14, "lw20_partial");

    // Zero wait states: aliasing through ignored upper address bits
    access(1, 0, 1, 32'h1000, 32'h55, 3'b010, 5'd0, 1'b0, 1, 0, 32'h0, 5'd0, "w0_sw1000");
    access(1, 1, 0, 32'h0, 32'h0, 3'b010, 5'd4, 1'b1, 1, 1, 32'h55, 5'd4, "w0_lw0_alias");
    access(1, 0, 1, 32'h4, 32'h77, 3'b010, 5'd0, 1'b0, 1, 0, 32'h55, 5'd4, "w0_sw4");

    // Zero wait states: back-to-back loads, second presented in the first's valid cycle
    sel = 1'b1;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 5'd1, 1'b1);
    @(negedge clk);
    check("b2b first accept stall", 32'(b_stall), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b first done stall", 32'(b_stall), 32'h0);
    check("b2b first not yet valid", 32'(b_valid), 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010, 5'd2, 1'b1);
    @(negedge clk);
    check("b2b first valid", 32'(b_valid), 32'h1);
    check("b2b first rdata", b_rdata, 32'h55);
    check("b2b first rd_idx", 32'(b_rd_idx), 32'd1);
    check("b2b second accept stall", 32'(b_stall), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b second done stall", 32'(b_stall), 32'h0);
    check("b2b gap valid", 32'(b_valid), 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check("b2b second valid", 32'(b_valid), 32'h1);
    check("b2b second rdata", b_rdata, 32'h77);
    check("b2b second rd_idx", 32'(b_rd_idx), 32'd2);
    check("b2b second rd_we", 32'(b_rd_we), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
